// File: rtl/ws_systolic_core_pkg.sv
// Shared types and sizing helpers for the weight-stationary systolic core.
//   state_t   : control FSM states
//   acc_w     : accumulator width that holds an N-term sum of DATA_W x DATA_W products
//   LATENCY_F : accept-to-result latency in cycles, also the tag pipeline depth
package ws_sa_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_W  = 2'd1,
        COMPUTE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    function automatic int acc_w(input int data_w, input int n);
        return 2 * data_w + $clog2(n);
    endfunction

    function automatic int LATENCY_F(input int n);
        return 2 * n;
    endfunction

endpackage

// File: rtl/ws_systolic_core_pe.sv
// One processing element of the weight-stationary array.
//   clk, reset : clock and asynchronous active-high reset
//   adv        : pipeline advance; when low every data register holds
//   w_load     : capture w_in into the stationary weight register
//   w_in       : weight for this PE
//   a_in       : activation arriving from the west
//   psum_in    : partial sum arriving from the north
//   a_out      : activation passed east (one cycle later)
//   psum_out   : psum_in + a_in * weight (one cycle later)
module ws_pe
    import ws_sa_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 18
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     adv,
    input  logic                     w_load,
    input  logic signed [DATA_W-1:0] w_in,
    input  logic signed [DATA_W-1:0] a_in,
    input  logic signed [ACC_W-1:0]  psum_in,
    output logic signed [DATA_W-1:0] a_out,
    output logic signed [ACC_W-1:0]  psum_out
);

    logic signed [DATA_W-1:0] w_q;
    logic signed [DATA_W-1:0] a_p0;
    logic signed [ACC_W-1:0]  psum_p0;
    logic signed [ACC_W-1:0]  a_ext;
    logic signed [ACC_W-1:0]  w_ext;
    logic signed [ACC_W-1:0]  mac;

    // Sign-extend both operands so the product and sum wrap modulo 2^ACC_W.
    assign a_ext = {{(ACC_W-DATA_W){a_in[DATA_W-1]}}, a_in};
    assign w_ext = {{(ACC_W-DATA_W){w_q[DATA_W-1]}}, w_q};
    assign mac   = psum_in + a_ext * w_ext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_q <= '0;
        end else if (w_load) begin
            w_q <= w_in;
        end
    end

    // Stage p0: east-bound activation and south-bound partial sum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_p0    <= '0;
            psum_p0 <= '0;
        end else if (adv) begin
            a_p0    <= a_in;
            psum_p0 <= mac;
        end
    end

    assign a_out    = a_p0;
    assign psum_out = psum_p0;

endmodule

// File: rtl/ws_systolic_core.sv
// Weight-stationary N x N systolic matrix-vector core.
//   clk, reset          : clock, asynchronous active-high reset (clears weights too)
//   wt_valid/ready/row  : weight rows 0..N-1 in order; element c at [c*DATA_W +: DATA_W]
//   act_valid/ready/vec : unskewed activation vector; lane r at [r*DATA_W +: DATA_W]
//   act_last            : marks the final vector of a batch
//   res_valid/ready/vec : y[c] = sum_r a[r]*W[r][c]; column c at [c*ACC_W +: ACC_W]
//   res_last            : result of the vector accepted with act_last
//   busy                : FSM not IDLE
module ws_systolic_core
    import ws_sa_pkg::*;
#(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = acc_w(DATA_W, N)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wt_valid,
    output logic                  wt_ready,
    input  logic [N*DATA_W-1:0]   wt_row,
    input  logic                  act_valid,
    output logic                  act_ready,
    input  logic [N*DATA_W-1:0]   act_vec,
    input  logic                  act_last,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [N*ACC_W-1:0]    res_vec,
    output logic                  res_last,
    output logic                  busy
);

    localparam int DEPTH = LATENCY_F(N);
    localparam int RW    = $clog2(N);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);

    state_t            state_q, state_d;
    logic [RW-1:0]     row_cnt;
    logic [RW-1:0]     wt_idx;
    logic [CW-1:0]     drain_cnt;
    logic              advance;
    logic              wt_fire;
    logic              act_fire;
    logic [DEPTH-1:0]  tag_vld;
    logic [DEPTH-1:0]  tag_last;

    logic signed [DATA_W-1:0] act_in [N];
    logic signed [DATA_W-1:0] a_h    [N][N+1];
    logic signed [ACC_W-1:0]  psum_v [N][N];

    // The whole datapath freezes only while a presented result is refused.
    assign advance  = !(res_valid && !res_ready);
    assign wt_fire  = wt_valid && wt_ready;
    assign act_fire = act_valid && act_ready;
    assign wt_idx   = (state_q == LOAD_W) ? row_cnt : '0;
    assign busy     = (state_q != IDLE);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (wt_fire) begin
                    state_d = LOAD_W;
                end else if (act_fire) begin
                    state_d = act_last ? DRAIN : COMPUTE;
                end
            end
            LOAD_W:  if (wt_fire && row_cnt == LAST_ROW) state_d = IDLE;
            COMPUTE: if (act_fire && act_last) state_d = DRAIN;
            DRAIN:   if (drain_cnt == '0 && (!res_valid || res_ready)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wt_ready  = 1'b0;
        act_ready = 1'b0;
        case (state_q)
            IDLE: begin
                wt_ready  = 1'b1;
                act_ready = !wt_valid;
            end
            LOAD_W:  wt_ready  = 1'b1;
            COMPUTE: act_ready = advance;
            default: ;
        endcase
        if (reset) act_ready = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_cnt   <= '0;
            drain_cnt <= '0;
        end else begin
            if (wt_fire) begin
                if (state_q == IDLE) row_cnt <= RW'(1);
                else if (row_cnt == LAST_ROW) row_cnt <= '0;
                else row_cnt <= row_cnt + RW'(1);
            end
            // Counts the tail of the batch still travelling through the array.
            if (act_fire && act_last) begin
                drain_cnt <= CW'(DEPTH);
            end else if (state_q == DRAIN && advance && drain_cnt != '0) begin
                drain_cnt <= drain_cnt - CW'(1);
            end
        end
    end

    // ---------------- skew: row r delayed by r stages ----------------
    for (genvar r = 0; r < N; r++) begin : g_skew
        assign act_in[r] = act_fire ? $signed(act_vec[r*DATA_W +: DATA_W]) : '0;
        if (r == 0) begin : g_direct
            assign a_h[0][0] = act_in[0];
        end else begin : g_sr
            logic signed [DATA_W-1:0] sk_p [r];
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < r; i++) sk_p[i] <= '0;
                end else if (advance) begin
                    sk_p[0] <= act_in[r];
                    for (int i = 1; i < r; i++) sk_p[i] <= sk_p[i-1];
                end
            end
            assign a_h[r][0] = sk_p[r-1];
        end
    end

    // ---------------- PE array ----------------
    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            logic signed [ACC_W-1:0] p_in;
            if (r == 0) begin : g_p0
                assign p_in = '0;
            end else begin : g_pn
                assign p_in = psum_v[r-1][c];
            end
            ws_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_pe (
                .clk      (clk),
                .reset    (reset),
                .adv      (advance),
                .w_load   (wt_fire && wt_idx == RW'(r)),
                .w_in     ($signed(wt_row[c*DATA_W +: DATA_W])),
                .a_in     (a_h[r][c]),
                .psum_in  (p_in),
                .a_out    (a_h[r][c+1]),
                .psum_out (psum_v[r][c])
            );
        end
    end

    // ---------------- deskew: column c delayed N-1-c stages, plus the output stage ----------------
    for (genvar c = 0; c < N; c++) begin : g_deskew
        logic signed [ACC_W-1:0] dq_p [N-c];
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < N - c; i++) dq_p[i] <= '0;
            end else if (advance) begin
                dq_p[0] <= psum_v[N-1][c];
                for (int i = 1; i < N - c; i++) dq_p[i] <= dq_p[i-1];
            end
        end
        assign res_vec[c*ACC_W +: ACC_W] = dq_p[N-1-c];
    end

    // ---------------- tag pipeline, aligned with the result stage ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_vld  <= '0;
            tag_last <= '0;
        end else if (advance) begin
            tag_vld  <= {tag_vld[DEPTH-2:0], act_fire};
            tag_last <= {tag_last[DEPTH-2:0], act_fire && act_last};
        end
    end

    assign res_valid = tag_vld[DEPTH-1];
    assign res_last  = tag_last[DEPTH-1];

endmodule
